// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares the single data-memory port between the core load/store unit and an
// external master (debug/DMA loader). Core has fixed priority, bounded by a
// starvation counter so a waiting external master wins after MAX_WAIT cycles.
// Grants are combinational; read data is registered per requester with a
// one-cycle valid strobe.
//
// Ports:
//   CLK, RST_N                      clock, async active-low reset
//   c_req/c_we/c_funct3/c_addr/c_wdata  core request and operands
//   c_gnt, c_rvalid, c_rdata        core grant and read response
//   e_req/e_we/e_funct3/e_addr/e_wdata  external master request and operands
//   e_gnt, e_rvalid, e_rdata        external master grant and read response
//   mem_A, mem_WD, mem_WE, mem_funct3   data-memory request side
//   mem_RD                          data-memory combinational read data
`timescale 1ns/1ps

module dmem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 3
) (
  input  logic              CLK,
  input  logic              RST_N,

  input  logic              c_req,
  input  logic              c_we,
  input  logic [2:0]        c_funct3,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,

  input  logic              e_req,
  input  logic              e_we,
  input  logic [2:0]        e_funct3,
  input  logic [ADDR_W-1:0] e_addr,
  input  logic [DATA_W-1:0] e_wdata,
  output logic              e_gnt,
  output logic              e_rvalid,
  output logic [DATA_W-1:0] e_rdata,

  output logic [ADDR_W-1:0] mem_A,
  output logic [DATA_W-1:0] mem_WD,
  output logic              mem_WE,
  output logic [2:0]        mem_funct3,
  input  logic [DATA_W-1:0] mem_RD
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  logic [3:0] wait_cnt;
  logic       force_e;

  // Only byte/half/word stores are legal; other codes are granted but dropped.
  function automatic logic store_ok(input logic [2:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
  endfunction

  assign force_e = (wait_cnt == MAX_WAIT_C);

  // Grants are gated by RST_N so nothing reaches memory while in reset.
  always_comb begin
    c_gnt = 1'b0;
    e_gnt = 1'b0;
    if (RST_N) begin
      if (c_req && e_req) begin
        e_gnt = force_e;
        c_gnt = !force_e;
      end else begin
        c_gnt = c_req;
        e_gnt = e_req;
      end
    end
  end

  // With no grant the port idles on the core operands, write disabled.
  always_comb begin
    mem_A      = c_addr;
    mem_WD     = c_wdata;
    mem_funct3 = c_funct3;
    mem_WE     = 1'b0;
    if (e_gnt) begin
      mem_A      = e_addr;
      mem_WD     = e_wdata;
      mem_funct3 = e_funct3;
      mem_WE     = e_we && store_ok(e_funct3);
    end else if (c_gnt) begin
      mem_WE = c_we && store_ok(c_funct3);
    end
  end

  // Counts cycles the external master has been refused; saturates so the
  // force condition stays asserted until it is actually granted.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wait_cnt <= '0;
    end else if (e_req && !e_gnt) begin
      if (wait_cnt < MAX_WAIT_C)
        wait_cnt <= wait_cnt + 4'd1;
    end else begin
      wait_cnt <= '0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      c_rvalid <= 1'b0;
      c_rdata  <= '0;
      e_rvalid <= 1'b0;
      e_rdata  <= '0;
    end else begin
      c_rvalid <= c_gnt && !c_we;
      e_rvalid <= e_gnt && !e_we;
      if (c_gnt && !c_we)
        c_rdata <= mem_RD;
      if (e_gnt && !e_we)
        e_rdata <= mem_RD;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
`timescale 1ns/1ps

module tb_dmem_arbiter;

  logic        CLK;
  logic        RST_N;
  logic        c_req, c_we, c_gnt, c_rvalid;
  logic [2:0]  c_funct3;
  logic [31:0] c_addr, c_wdata, c_rdata;
  logic        e_req, e_we, e_gnt, e_rvalid;
  logic [2:0]  e_funct3;
  logic [31:0] e_addr, e_wdata, e_rdata;
  logic [31:0] mem_A, mem_WD, mem_RD;
  logic        mem_WE;
  logic [2:0]  mem_funct3;

  int checks = 0;
  int errors = 0;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(3)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .c_req(c_req), .c_we(c_we), .c_funct3(c_funct3), .c_addr(c_addr),
    .c_wdata(c_wdata), .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .e_req(e_req), .e_we(e_we), .e_funct3(e_funct3), .e_addr(e_addr),
    .e_wdata(e_wdata), .e_gnt(e_gnt), .e_rvalid(e_rvalid), .e_rdata(e_rdata),
    .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE), .mem_funct3(mem_funct3),
    .mem_RD(mem_RD)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Small data memory: word array indexed by addr[9:2], load formatting by funct3.
  logic [31:0] mem_arr [0:255];
  logic [31:0] rd_word, rd_shift;

  initial for (int k = 0; k < 256; k++) mem_arr[k] = 32'h0;

  always_comb begin
    rd_word  = mem_arr[mem_A[9:2]];
    rd_shift = rd_word >> (8 * mem_A[1:0]);
    case (mem_funct3)
      3'b000:  mem_RD = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  mem_RD = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  mem_RD = {24'h0, rd_shift[7:0]};
      3'b101:  mem_RD = {16'h0, rd_shift[15:0]};
      default: mem_RD = rd_word;
    endcase
  end

  always @(posedge CLK) begin
    if (mem_WE) begin
      case (mem_funct3)
        3'b000: mem_arr[mem_A[9:2]][8*mem_A[1:0] +: 8] <= mem_WD[7:0];
        3'b001: mem_arr[mem_A[9:2]][16*mem_A[1] +: 16] <= mem_WD[15:0];
        default: mem_arr[mem_A[9:2]] <= mem_WD;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  bit exp_e, prev_c, prev_e;

  initial begin
    RST_N = 1'b0;
    c_req = 1'b1; c_we = 1'b0; c_funct3 = 3'b010; c_addr = 32'h8000_0010; c_wdata = 32'h0;
    e_req = 1'b1; e_we = 1'b0; e_funct3 = 3'b010; e_addr = 32'h8000_0020; e_wdata = 32'h0;

    // Reset holds everything quiet even with both requesting
    #3;
    chk("rst_c_gnt", {31'h0, c_gnt}, 32'h0);
    chk("rst_e_gnt", {31'h0, e_gnt}, 32'h0);
    chk("rst_mem_we", {31'h0, mem_WE}, 32'h0);
    tick(); tick();
    chk("rst_c_rvalid", {31'h0, c_rvalid}, 32'h0);
    chk("rst_e_rvalid", {31'h0, e_rvalid}, 32'h0);
    chk("rst_c_rdata", c_rdata, 32'h0);
    chk("rst_e_rdata", e_rdata, 32'h0);

    RST_N = 1'b1;
    #1;
    chk("rel_c_gnt", {31'h0, c_gnt}, 32'h1);
    chk("rel_e_gnt", {31'h0, e_gnt}, 32'h0);
    c_req = 1'b0; e_req = 1'b0;
    tick();

    // Core sw then lw
    c_req = 1'b1; c_we = 1'b1; c_funct3 = 3'b010; c_addr = 32'h8000_0010; c_wdata = 32'hDEAD_BEEF;
    #1;
    chk("sw_c_gnt", {31'h0, c_gnt}, 32'h1);
    chk("sw_mem_we", {31'h0, mem_WE}, 32'h1);
    chk("sw_mem_a", mem_A, 32'h8000_0010);
    chk("sw_mem_wd", mem_WD, 32'hDEAD_BEEF);
    tick();
    c_we = 1'b0;
    #1;
    chk("lw_c_gnt", {31'h0, c_gnt}, 32'h1);
    chk("sw_no_rvalid", {31'h0, c_rvalid}, 32'h0);
    tick();
    c_req = 1'b0;
    #1;
    chk("lw_c_rvalid", {31'h0, c_rvalid}, 32'h1);
    chk("lw_c_rdata", c_rdata, 32'hDEAD_BEEF);
    tick();
    chk("lw_rvalid_drop", {31'h0, c_rvalid}, 32'h0);

    // Starvation bound: both requesting continuously, external wins every 4th cycle
    prev_c = 1'b0; prev_e = 1'b0;
    for (int i = 0; i < 8; i++) begin
      c_req = 1'b1; c_we = 1'b0; c_funct3 = 3'b010; c_addr = 32'h8000_0010;
      e_req = 1'b1; e_we = 1'b0; e_funct3 = 3'b010; e_addr = 32'h8000_0020;
      #1;
      exp_e = ((i % 4) == 3);
      chk($sformatf("starve_c_gnt_%0d", i), {31'h0, c_gnt}, {31'h0, !exp_e});
      chk($sformatf("starve_e_gnt_%0d", i), {31'h0, e_gnt}, {31'h0, exp_e});
      chk($sformatf("starve_mem_a_%0d", i), mem_A, exp_e ? 32'h8000_0020 : 32'h8000_0010);
      if (i > 0) begin
        chk($sformatf("starve_c_rvalid_%0d", i), {31'h0, c_rvalid}, {31'h0, prev_c});
        chk($sformatf("starve_e_rvalid_%0d", i), {31'h0, e_rvalid}, {31'h0, prev_e});
        if (prev_c) chk($sformatf("starve_c_rdata_%0d", i), c_rdata, 32'hDEAD_BEEF);
      end
      prev_c = !exp_e;
      prev_e = exp_e;
      tick();
    end
    c_req = 1'b0; e_req = 1'b0;
    #1;
    chk("starve_end_e_rvalid", {31'h0, e_rvalid}, 32'h1);
    chk("starve_end_c_rvalid", {31'h0, c_rvalid}, 32'h0);
    chk("starve_end_e_rdata", e_rdata, 32'h0);
    tick();

    // External sb 0x80, then lb and lbu of the same byte
    e_req = 1'b1; e_we = 1'b1; e_funct3 = 3'b000; e_addr = 32'h8000_0031; e_wdata = 32'h0000_0080;
    #1;
    chk("sb_e_gnt", {31'h0, e_gnt}, 32'h1);
    chk("sb_mem_we", {31'h0, mem_WE}, 32'h1);
    chk("sb_mem_a", mem_A, 32'h8000_0031);
    tick();
    e_we = 1'b0;
    #1;
    chk("sb_no_rvalid", {31'h0, e_rvalid}, 32'h0);
    tick();
    e_funct3 = 3'b100;
    #1;
    chk("lb_e_rvalid", {31'h0, e_rvalid}, 32'h1);
    chk("lb_e_rdata", e_rdata, 32'hFFFF_FF80);
    chk("lb_c_rvalid", {31'h0, c_rvalid}, 32'h0);
    tick();
    e_req = 1'b0;
    #1;
    chk("lbu_e_rvalid", {31'h0, e_rvalid}, 32'h1);
    chk("lbu_e_rdata", e_rdata, 32'h0000_0080);
    chk("lbu_c_rvalid", {31'h0, c_rvalid}, 32'h0);
    tick();

    // Illegal store size is granted but never reaches memory
    c_req = 1'b1; c_we = 1'b1; c_funct3 = 3'b011; c_addr = 32'h8000_0010; c_wdata = 32'h1234_5678;
    #1;
    chk("bad_c_gnt", {31'h0, c_gnt}, 32'h1);
    chk("bad_mem_we", {31'h0, mem_WE}, 32'h0);
    tick();
    c_we = 1'b0; c_funct3 = 3'b010;
    #1;
    chk("bad_no_rvalid", {31'h0, c_rvalid}, 32'h0);
    tick();
    c_req = 1'b0;
    #1;
    chk("bad_lw_rvalid", {31'h0, c_rvalid}, 32'h1);
    chk("bad_lw_rdata", c_rdata, 32'hDEAD_BEEF);
    tick();

    // Reset right at the edge that closes a read grant: no response survives
    c_req = 1'b1; c_we = 1'b0; c_funct3 = 3'b010; c_addr = 32'h8000_0010;
    #1;
    chk("rstrd_c_gnt", {31'h0, c_gnt}, 32'h1);
    @(posedge CLK);
    RST_N = 1'b0;
    c_req = 1'b0;
    #1;
    chk("rstrd_c_rvalid", {31'h0, c_rvalid}, 32'h0);
    chk("rstrd_c_rdata", c_rdata, 32'h0);
    #2;
    RST_N = 1'b1;
    tick();
    chk("rstrd_c_rvalid_after", {31'h0, c_rvalid}, 32'h0);
    chk("rstrd_c_rdata_after", c_rdata, 32'h0);
    chk("rstrd_c_gnt_after", {31'h0, c_gnt}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter that shares the single data-memory port between the core load/store unit and an external master (debug/DMA loader). It sits directly in front of the data memory and drives its address, write-data, write-enable and funct3 inputs. It returns registered read data with a valid strobe one cycle after grant. Fixed core priority is bounded by a starvation counter so the external master always progresses.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_WAIT, 3, max cycles the external master may wait while requesting before it is forced to win (1..15)
- CLK  in  1  clock, all state updates on rising edge
- RST_N  in  1  asynchronous, active-low reset
- c_req  in  1  core request; held with operands until granted
- c_we  in  1  core write (1) / read (0)
- c_funct3  in  3  core access size/sign code (000 b, 001 h, 010 w, 100 bu, 101 hu)
- c_addr  in  ADDR_W  core address
- c_wdata  in  DATA_W  core write data
- c_gnt  out  1  core request accepted this cycle
- c_rvalid  out  1  core read data valid
- c_rdata  out  DATA_W  core read data
- e_req, e_we, e_funct3, e_addr, e_wdata  in  1/1/3/ADDR_W/DATA_W  external master request, same meaning as core
- e_gnt, e_rvalid, e_rdata  out  1/1/DATA_W  external master grant/response, same meaning as core
- mem_A  out  ADDR_W  memory address
- mem_WD  out  DATA_W  memory write data
- mem_WE  out  1  memory write enable
- mem_funct3  out  3  memory access size code
- mem_RD  in  DATA_W  memory combinational read data

## Operation
- At most one access per cycle; transfer occurs when req && gnt.
- Grant (combinational from req and wait_cnt): only one requesting -> it wins; both requesting -> core wins unless wait_cnt == MAX_WAIT, then external wins.
- wait_cnt (4-bit): increments when e_req && !e_gnt, saturating at MAX_WAIT; clears on e_gnt or when !e_req.
- Winner's addr, wdata, funct3 drive mem_A, mem_WD, mem_funct3; with no grant, mem_* hold core inputs and mem_WE = 0.
- mem_WE = winner_we, except writes with funct3 outside {000,001,010} are still granted but mem_WE forced 0 (silently dropped).
- Read grant: mem_RD captured at the rising edge into the winner's rdata register; winner's rvalid = 1 for exactly the next cycle. rdata holds its value until the next read by that requester.
- Write grant: rvalid stays 0; write commits at the same rising edge.
- Loser keeps gnt = 0; must hold req and operands stable.

## Timing
- Reset (RST_N low, asynchronous): c_rvalid = e_rvalid = 0, c_rdata = e_rdata = 0, wait_cnt = 0; while RST_N low, c_gnt = e_gnt = mem_WE = 0 regardless of req.
- Grant latency: 0 cycles (same cycle as req when winning). Read latency: rvalid 1 cycle after grant cycle.
- Back-to-back: one requester may be granted every cycle; rvalid then high continuously with new rdata each cycle.
- Worst-case external wait under continuous core traffic: MAX_WAIT cycles, then granted on cycle MAX_WAIT+1.
- Reset asserted mid-read: pending rvalid is cleared, no response delivered; the transfer is not retried.
- Simultaneous core and external write to the same address: only the winner writes that cycle; loser writes a later cycle (last-granted wins).

## Test plan
- Reset: RST_N low with c_req=e_req=1 -> both gnt=0, mem_WE=0, rvalid=0, rdata=0; release -> core granted first cycle.
- Core sw 0xDEADBEEF to 0x8000_0010, then lw same address -> c_gnt each cycle, c_rvalid one cycle after read grant, c_rdata=0xDEADBEEF.
- Starvation: c_req and e_req held high continuously, MAX_WAIT=3 -> core granted cycles 0-2, external granted cycle 3, wait_cnt then 0, pattern repeats.
- External lb from byte holding 0x80 -> e_rdata=0xFFFF_FF80; lbu same -> 0x0000_0080; c_rvalid stays 0.
- Write with funct3=011 -> gnt=1, mem_WE=0, subsequent lw shows memory unchanged.
- RST_N pulsed low in the cycle after a core read grant -> c_rvalid never asserts, c_rdata=0.
